// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready result side.
// Shifts take one cycle per bit. Flags are generated only when ALU_SEQ_FLAGS_EN is defined, otherwise tied to 0.
module alu_seq #(
  parameter int NB_DATA      = 8,
  parameter int NB_OPERATION = 6
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NB_OPERATION-1:0] i_op,
  input  logic [NB_DATA-1:0]      i_data_a,
  input  logic [NB_DATA-1:0]      i_data_b,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NB_DATA-1:0]      o_result,
  output logic                    o_err,
  output logic                    o_zero,
  output logic                    o_carry,
  output logic                    o_overflow,
  output logic                    o_negative
);

  localparam int CW = $clog2(NB_DATA + 1);
  localparam int MSB = NB_DATA - 1;
  localparam logic [CW-1:0]           CNT_MAX = CW'(NB_DATA);
  localparam logic [NB_DATA-1:0]      B_LIM   = NB_DATA'(NB_DATA);

  localparam logic [NB_OPERATION-1:0] OP_ADD = NB_OPERATION'(4'b1000);
  localparam logic [NB_OPERATION-1:0] OP_SUB = NB_OPERATION'(4'b1010);
  localparam logic [NB_OPERATION-1:0] OP_AND = NB_OPERATION'(4'b1100);
  localparam logic [NB_OPERATION-1:0] OP_OR  = NB_OPERATION'(4'b1101);
  localparam logic [NB_OPERATION-1:0] OP_XOR = NB_OPERATION'(4'b1110);
  localparam logic [NB_OPERATION-1:0] OP_NOR = NB_OPERATION'(4'b1111);
  localparam logic [NB_OPERATION-1:0] OP_SRL = NB_OPERATION'(4'b0010);
  localparam logic [NB_OPERATION-1:0] OP_SRA = NB_OPERATION'(4'b0011);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nx;
  logic               accept;
  logic               is_shift;
  logic [CW-1:0]      k_in;
  logic [CW-1:0]      cnt;
  logic               sra_q;
  logic [NB_DATA-1:0] acc;
  logic               err_q;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_err;
  logic [NB_DATA-1:0] shift_nx;

  assign accept   = i_valid && (state == IDLE);
  assign is_shift = (i_op == OP_SRL) || (i_op == OP_SRA);
  // Counts at or beyond the width saturate: NB_DATA steps already flush every original bit.
  assign k_in     = (i_data_b >= B_LIM) ? CNT_MAX : i_data_b[CW-1:0];
  assign shift_nx = {sra_q ? acc[MSB] : 1'b0, acc[MSB:1]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_shift && (k_in != '0)) begin
            state_nx = SHIFT;
          end else begin
            state_nx = DONE;
          end
        end
      end
      SHIFT: begin
        if (cnt == CW'(1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  // Shift opcodes load the unshifted operand; SHIFT then walks it one bit per cycle.
  always_comb begin
    alu_res = '1;
    alu_err = 1'b0;
    case (i_op)
      OP_ADD:  alu_res = i_data_a + i_data_b;
      OP_SUB:  alu_res = i_data_a - i_data_b;
      OP_AND:  alu_res = i_data_a & i_data_b;
      OP_OR:   alu_res = i_data_a | i_data_b;
      OP_XOR:  alu_res = i_data_a ^ i_data_b;
      OP_NOR:  alu_res = ~(i_data_a | i_data_b);
      OP_SRL:  alu_res = i_data_a;
      OP_SRA:  alu_res = i_data_a;
      default: begin
        alu_res = '1;
        alu_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc   <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
      sra_q <= 1'b0;
    end else if (accept) begin
      acc   <= alu_res;
      err_q <= alu_err;
      cnt   <= k_in;
      sra_q <= (i_op == OP_SRA);
    end else if (state == SHIFT) begin
      acc <= shift_nx;
      cnt <= cnt - CW'(1);
    end
  end

  assign o_result = acc;
  assign o_err    = err_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q;
  logic neg_q;
  logic carry_q;
  logic ovf_q;
  logic ld_carry;
  logic ld_ovf;

  // Carry of a modulo add is detectable as wrap-around: sum < a.
  always_comb begin
    ld_carry = 1'b0;
    ld_ovf   = 1'b0;
    case (i_op)
      OP_ADD: begin
        ld_carry = (alu_res < i_data_a);
        ld_ovf   = (i_data_a[MSB] == i_data_b[MSB]) && (alu_res[MSB] != i_data_a[MSB]);
      end
      OP_SUB: begin
        ld_carry = (i_data_a < i_data_b);
        ld_ovf   = (i_data_a[MSB] != i_data_b[MSB]) && (alu_res[MSB] != i_data_a[MSB]);
      end
      default: begin
        ld_carry = 1'b0;
        ld_ovf   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      zero_q  <= (alu_res == '0);
      neg_q   <= alu_res[MSB];
      carry_q <= ld_carry;
      ovf_q   <= ld_ovf;
    end else if (state == SHIFT) begin
      zero_q  <= (shift_nx == '0);
      neg_q   <= shift_nx[MSB];
      carry_q <= acc[0];
      ovf_q   <= 1'b0;
    end
  end

  assign o_zero     = zero_q;
  assign o_negative = neg_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;
`else
  assign o_zero     = 1'b0;
  assign o_negative = 1'b0;
  assign o_carry    = 1'b0;
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq against an arithmetic reference model; flag expectations follow ALU_SEQ_FLAGS_EN.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [5:0] op;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       out_valid;
  logic       in_ready;
  logic [7:0] result;
  logic       err;
  logic       zero;
  logic       carry;
  logic       overflow;
  logic       negative;

  int total = 0;
  int bad   = 0;

  alu_seq #(.NB_DATA(8), .NB_OPERATION(6)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_valid(in_valid),
    .o_ready(out_ready),
    .i_op(op),
    .i_data_a(data_a),
    .i_data_b(data_b),
    .o_valid(out_valid),
    .i_ready(in_ready),
    .o_result(result),
    .o_err(err),
    .o_zero(zero),
    .o_carry(carry),
    .o_overflow(overflow),
    .o_negative(negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands, no notion of cycles except the latency count.
  function automatic void model(input logic [5:0] m_op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic m_err, output logic [3:0] flg,
                                output int lat);
    int ai, bi, sa, sb, s, k, r;
    logic c, v;
    ai = int'(a);
    bi = int'(b);
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    k  = (bi > 8) ? 8 : bi;
    c = 1'b0; v = 1'b0; m_err = 1'b0; lat = 1; r = 255;
    case (m_op)
      6'h08: begin r = (ai + bi) % 256; c = (ai + bi) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
      6'h0A: begin r = (ai - bi + 256) % 256; c = ai < bi; s = sa - sb; v = (s > 127) || (s < -128); end
      6'h0C: r = ai & bi;
      6'h0D: r = ai | bi;
      6'h0E: r = ai ^ bi;
      6'h0F: r = (~(ai | bi)) & 255;
      6'h02: begin
        r = (ai >> k) & 255;
        c = (k == 0) ? 1'b0 : 1'((ai >> (k - 1)) & 1);
        lat = 1 + k;
      end
      6'h03: begin
        r = (sa >>> k) & 255;
        c = (k == 0) ? 1'b0 : 1'((sa >>> (k - 1)) & 1);
        lat = 1 + k;
      end
      default: begin r = 255; m_err = 1'b1; end
    endcase
    res = 8'(r);
`ifdef ALU_SEQ_FLAGS_EN
    flg = {res == 8'h00, c, v, res[7]};
`else
    flg = 4'b0000;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b0;
  endtask

  // One transaction: accept, wait for result with junk on the inputs, hold, then release.
  task automatic run_op(input logic [5:0] t_op, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [7:0] e_res;
    logic       e_err;
    logic [3:0] e_flg;
    int         e_lat;
    int         cyc;
    model(t_op, a, b, e_res, e_err, e_flg, e_lat);
    chk("ready_before_accept", 32'(out_ready), 32'd1);
    in_valid = 1'b1;
    op = t_op; data_a = a; data_b = b;
    step();
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      chk("ready_busy", 32'(out_ready), 32'd0);
      in_valid = 1'($urandom); in_ready = 1'($urandom);
      op = 6'($urandom); data_a = 8'($urandom); data_b = 8'($urandom);
      step();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(e_lat));
    if (out_valid !== 1'b1) begin
      do_reset();
      return;
    end
    in_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      op = 6'($urandom); data_a = 8'($urandom); data_b = 8'($urandom);
      chk("hold_result", 32'(result), 32'(e_res));
      chk("hold_ready", 32'(out_ready), 32'd0);
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    chk("result", 32'(result), 32'(e_res));
    chk("err", 32'(err), 32'(e_err));
    chk("flags_zcvn", 32'({zero, carry, overflow, negative}), 32'(e_flg));
    in_valid = 1'b0;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(out_ready), 32'd1);
  endtask

  logic [5:0] legal_ops [8] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02, 6'h03};

  initial begin
    int seen;
    logic [5:0] r_op;
    logic [7:0] r_b;
    rst = 1'b1; in_valid = 1'b0; in_ready = 1'b0; op = '0; data_a = '0; data_b = '0;
    step();
    in_valid = 1'b1; in_ready = 1'b1;
    step();
    chk("rst_ready", 32'(out_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({result, err, zero, carry, overflow, negative}), 32'd0);
    rst = 1'b0; in_valid = 1'b0; in_ready = 1'b0;

    run_op(6'h08, 8'hFF, 8'h01, 0);
    run_op(6'h0A, 8'h80, 8'h01, 1);
    run_op(6'h03, 8'h90, 8'd3, 0);
    run_op(6'h02, 8'h81, 8'd1, 0);
    run_op(6'h02, 8'hA5, 8'd200, 2);
    run_op(6'h3F, 8'h12, 8'h34, 5);
    run_op(6'h03, 8'h80, 8'd8, 0);
    run_op(6'h02, 8'h5A, 8'd0, 0);
    run_op(6'h0F, 8'h0F, 8'h30, 0);

    // Reset in the middle of a shift, colliding with valid and ready.
    in_valid = 1'b1; op = 6'h02; data_a = 8'hFF; data_b = 8'd7;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1; in_valid = 1'b1; in_ready = 1'b1; op = 6'h08;
    step();
    rst = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
    chk("midshift_rst_valid", 32'(out_valid), 32'd0);
    chk("midshift_rst_ready", 32'(out_ready), 32'd1);
    chk("midshift_rst_outputs", 32'({result, err, zero, carry, overflow, negative}), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    chk("discarded_never_valid", 32'(seen), 32'd0);

    for (int n = 0; n < 250; n++) begin
      r_op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 7)] : 6'($urandom);
      r_b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      run_op(r_op, 8'($urandom), r_b, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
